// File: rtl/alu_ctrl_pkg.sv
// Shared encodings and buffer-entry layout for the ALU issue controller.
package alu_ctrl_pkg;

    // Supported major opcodes
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    // func7 values that alu_top understands
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // func3 encodings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Buffer entry: {result, flags, rd, illegal}
    localparam int FLAGS_W = 4;

    function automatic int entry_width(input int xlen, input int rd_w);
        return xlen + FLAGS_W + rd_w + 1;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Issue-side and writeback-side handshake bundle of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_op1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic [6:0]      in_opcode;
    logic [2:0]      in_func3;
    logic [6:0]      in_func7;
    logic [RD_W-1:0] in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [3:0]      out_flags;
    logic [RD_W-1:0] out_rd;
    logic            out_illegal;

    // Pipeline side: drives ops in, consumes results
    modport master (
        output in_valid, in_op1, in_rs2, in_imm, in_opcode, in_func3, in_func7, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_rd, out_illegal
    );

    // Controller side
    modport slave (
        input  in_valid, in_op1, in_rs2, in_imm, in_opcode, in_func3, in_func7, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Operand select, func7 legalisation and illegal-encoding detection for alu_top.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [XLEN-1:0] alu_imm,
    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_func3,
    output logic [6:0]      alu_func7,
    output logic            illegal
);
    logic       is_r;
    logic       is_i;
    logic [6:0] imm_f7;
    logic [6:0] f7_leg;

    // Classify the op, flag bad encodings, and zero the ALU drive for them
    always_comb begin
        is_r   = (opcode == OPC_RTYPE);
        is_i   = (opcode == OPC_ITYPE);
        imm_f7 = imm[11:5];

        illegal = 1'b0;
        if (!is_r && !is_i)
            illegal = 1'b1;
        if (is_r && func7 != F7_BASE && func7 != F7_ALT)
            illegal = 1'b1;
        if (is_r && func7 == F7_ALT && func3 != F3_ADD && func3 != F3_SR)
            illegal = 1'b1;
        if (is_i && func3 == F3_SLL && imm_f7 != F7_BASE)
            illegal = 1'b1;
        if (is_i && func3 == F3_SR && imm_f7 != F7_BASE && imm_f7 != F7_ALT)
            illegal = 1'b1;

        // I-type shifts carry func7 in the immediate; ADDI must never subtract
        if (is_r)
            f7_leg = func7;
        else if (func3 == F3_SR)
            f7_leg = imm_f7;
        else
            f7_leg = F7_BASE;

        alu_op1    = '0;
        alu_op2    = '0;
        alu_imm    = '0;
        alu_opcode = '0;
        alu_func3  = '0;
        alu_func7  = '0;
        if (!illegal) begin
            alu_op1    = op1;
            alu_op2    = is_r ? rs2 : imm;
            alu_imm    = imm;
            alu_opcode = opcode;
            alu_func3  = func3;
            alu_func7  = f7_leg;
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: drives the shared alu_top, captures results into a
// 2-entry skid buffer toward EX/MEM and counts illegal ops.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_issue_ctrl_if.slave     bus,
    output logic [XLEN-1:0]     alu_op1,
    output logic [XLEN-1:0]     alu_op2,
    output logic [XLEN-1:0]     alu_imm,
    output logic [6:0]          alu_opcode,
    output logic [2:0]          alu_func3,
    output logic [6:0]          alu_func7,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [FLAGS_W-1:0]  alu_flags,
    output logic [CNT_W-1:0]    illegal_cnt
);
    typedef struct packed {
        logic [XLEN-1:0]    result;
        logic [FLAGS_W-1:0] flags;
        logic [RD_W-1:0]    rd;
        logic               illegal;
    } entry_t;

    logic       illegal;
    logic       accept;
    logic       pop;
    logic [1:0] count;
    logic       head;
    logic       tail;
    entry_t     mem [2];
    entry_t     new_e;
    entry_t     head_e;

    alu_op_decode #(.XLEN(XLEN)) u_dec (
        .op1        (bus.in_op1),
        .rs2        (bus.in_rs2),
        .imm        (bus.in_imm),
        .opcode     (bus.in_opcode),
        .func3      (bus.in_func3),
        .func7      (bus.in_func7),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_imm    (alu_imm),
        .alu_opcode (alu_opcode),
        .alu_func3  (alu_func3),
        .alu_func7  (alu_func7),
        .illegal    (illegal)
    );

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign accept        = bus.in_valid & bus.in_ready & ~flush;
    assign pop           = bus.out_valid & bus.out_ready;

    // Entry to capture this cycle; illegal ops never leak ALU output
    always_comb begin
        new_e         = '0;
        new_e.rd      = bus.in_rd;
        new_e.illegal = illegal;
        if (!illegal) begin
            new_e.result = alu_result;
            new_e.flags  = alu_flags;
        end
    end

    // Head of the buffer on the output, zero when empty
    always_comb begin
        head_e = '0;
        if (count != 2'd0)
            head_e = mem[head];
    end

    assign bus.out_result  = head_e.result;
    assign bus.out_flags   = head_e.flags;
    assign bus.out_rd      = head_e.rd;
    assign bus.out_illegal = head_e.illegal;

    // Skid buffer storage, pointers and occupancy; flush beats push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            head   <= 1'b0;
            tail   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (accept) begin
                mem[tail] <= new_e;
                tail      <= ~tail;
            end
            if (pop)
                head <= ~head;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of accepted illegal ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (accept && illegal && !(&illegal_cnt))
            illegal_cnt <= illegal_cnt + 1'b1;
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural alu_top stand-in, table-driven op
// stream checked through a scoreboard, plus hand-written corner sequences.
module tb_alu_issue_ctrl;
    localparam int XLEN  = 32;
    localparam int RD_W  = 5;
    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0] op1, rs2, imm;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic [4:0]  rd;
        logic        illegal;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic [31:0] alu_op1, alu_op2, alu_imm, alu_result;
    logic [6:0]  alu_opcode, alu_func7;
    logic [2:0]  alu_func3;
    logic [3:0]  alu_flags;
    logic [CNT_W-1:0] illegal_cnt;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pop_cnt = 0;
    int   first_pop = 0;
    int   last_pop = 0;
    int   exp_cnt = 0;
    ent_t sb[$];
    vec_t vecs[14];

    alu_issue_ctrl_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    alu_issue_ctrl #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_imm     (alu_imm),
        .alu_opcode  (alu_opcode),
        .alu_func3   (alu_func3),
        .alu_func7   (alu_func7),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // alu_top behaviour: returns {carry, zero, negative, overflow, result}
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f3, input logic [6:0] f7);
        logic [32:0] s;
        logic [31:0] r;
        logic c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (f3)
            3'd0: begin
                if (f7[5]) begin
                    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                    r = s[31:0];
                    v = (a[31] != b[31]) && (r[31] != a[31]);
                end else begin
                    s = {1'b0, a} + {1'b0, b};
                    r = s[31:0];
                    v = (a[31] == b[31]) && (r[31] != a[31]);
                end
                c = s[32];
            end
            3'd1: r = a << b[4:0];
            3'd2: r = {31'd0, $signed(a) < $signed(b)};
            3'd3: r = {31'd0, a < b};
            3'd4: r = a ^ b;
            3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {c, (r == 32'd0), r[31], v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_op1, alu_op2, alu_func3, alu_func7);

    // Expected buffer entry derived from the raw instruction fields
    function automatic ent_t ref_exp(input op_t o);
        logic        is_r, is_i, ill;
        logic [6:0]  if7, f7;
        logic [31:0] b;
        logic [35:0] m;
        ent_t        e;
        is_r = (o.opcode == 7'b0110011);
        is_i = (o.opcode == 7'b0010011);
        if7  = o.imm[11:5];
        ill  = (!is_r && !is_i)
            || (is_r && o.f7 != 7'h00 && o.f7 != 7'h20)
            || (is_r && o.f7 == 7'h20 && o.f3 != 3'd0 && o.f3 != 3'd5)
            || (is_i && o.f3 == 3'd1 && if7 != 7'h00)
            || (is_i && o.f3 == 3'd5 && if7 != 7'h00 && if7 != 7'h20);
        b  = is_r ? o.rs2 : o.imm;
        f7 = is_r ? o.f7 : ((o.f3 == 3'd5) ? if7 : 7'h00);
        m  = alu_model(o.op1, b, o.f3, f7);
        e.result  = ill ? 32'd0 : m[31:0];
        e.flags   = ill ? 4'd0 : m[35:32];
        e.rd      = o.rd;
        e.illegal = ill;
        return e;
    endfunction

    function automatic op_t mk(input logic [31:0] op1, input logic [31:0] rs2, input logic [31:0] imm,
                               input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd);
        op_t o;
        o.op1 = op1; o.rs2 = rs2; o.imm = imm; o.opcode = opc; o.f3 = f3; o.f7 = f7; o.rd = rd;
        return o;
    endfunction

    function automatic vec_t mkv(input op_t o, input logic [31:0] res, input logic ill);
        vec_t v;
        v.op = o; v.res = res; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input op_t o);
        bus.in_op1    = o.op1;
        bus.in_rs2    = o.rs2;
        bus.in_imm    = o.imm;
        bus.in_opcode = o.opcode;
        bus.in_func3  = o.f3;
        bus.in_func7  = o.f7;
        bus.in_rd     = o.rd;
    endtask

    // Present an op, wait (bounded) for in_ready, record its expected entry
    task automatic issue(input op_t o, input ent_t e);
        int waitc;
        waitc = 0;
        set_in(o);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=in_ready_low required=in_ready_high");
        end else begin
            sb.push_back(e);
            if (e.illegal && exp_cnt != 15) exp_cnt++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard: compare each popped head against the oldest expectation
    always @(negedge clk) begin : mon
        ent_t e;
        if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h required=none", bus.out_result);
            end else begin
                e = sb.pop_front();
                chk("sb_entry", {bus.out_result, bus.out_flags, bus.out_rd, bus.out_illegal}, e);
            end
            pop_cnt++;
            if (pop_cnt == 1) first_pop = cyc;
            last_pop = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t  o;
        ent_t e;
        vecs[0]  = mkv(mk(32'd10, 32'd20, 32'h0FFF, 7'h33, 3'd0, 7'h00, 5'd1), 32'd30, 1'b0);
        vecs[1]  = mkv(mk(32'd5, 32'd7, 32'h0FFF, 7'h33, 3'd0, 7'h20, 5'd2), 32'hFFFF_FFFE, 1'b0);
        vecs[2]  = mkv(mk(32'hFFFF_FFE0, 32'hDEAD_BEEF, 32'h0403, 7'h13, 3'd5, 7'h7F, 5'd3), 32'hFFFF_FFFC, 1'b0);
        vecs[3]  = mkv(mk(32'hFFFF_FFE0, 32'hDEAD_BEEF, 32'h0003, 7'h13, 3'd5, 7'h7F, 5'd4), 32'h1FFF_FFFC, 1'b0);
        vecs[4]  = mkv(mk(32'd1, 32'hDEAD_BEEF, 32'h0400, 7'h13, 3'd0, 7'h7F, 5'd5), 32'h0000_0401, 1'b0);
        vecs[5]  = mkv(mk(32'hFFFF_FFFF, 32'd1, 32'h0FFF, 7'h33, 3'd2, 7'h00, 5'd6), 32'd1, 1'b0);
        vecs[6]  = mkv(mk(32'hFFFF_FFFF, 32'd1, 32'h0FFF, 7'h33, 3'd3, 7'h00, 5'd7), 32'd0, 1'b0);
        vecs[7]  = mkv(mk(32'h0000_F0F0, 32'hDEAD_BEEF, 32'h00FF, 7'h13, 3'd7, 7'h7F, 5'd8), 32'h0000_00F0, 1'b0);
        vecs[8]  = mkv(mk(32'd1, 32'd2, 32'h0FFF, 7'h33, 3'd0, 7'h01, 5'd9), 32'd0, 1'b1);
        vecs[9]  = mkv(mk(32'd1, 32'd2, 32'h0405, 7'h13, 3'd1, 7'h00, 5'd10), 32'd0, 1'b1);
        vecs[10] = mkv(mk(32'd1, 32'd2, 32'h0004, 7'h03, 3'd0, 7'h00, 5'd11), 32'd0, 1'b1);
        vecs[11] = mkv(mk(32'd1, 32'd2, 32'h0FFF, 7'h33, 3'd7, 7'h20, 5'd12), 32'd0, 1'b1);
        vecs[12] = mkv(mk(32'd3, 32'hDEAD_BEEF, 32'h0004, 7'h13, 3'd1, 7'h7F, 5'd13), 32'h0000_0030, 1'b0);
        vecs[13] = mkv(mk(32'h0000_00A0, 32'h0000_000B, 32'h0FFF, 7'h33, 3'd6, 7'h00, 5'd14), 32'h0000_00AB, 1'b0);

        // Reset state
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_in(mk(32'd0, 32'd0, 32'd0, 7'h00, 3'd0, 7'h00, 5'd0));
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_illegal", bus.out_illegal, 1'b0);
        chk("rst_illegal_cnt", illegal_cnt, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Combinational ALU drive: SRAI legalisation and illegal zeroing
        set_in(vecs[2].op);
        #1;
        chk("srai_alu_func7", alu_func7, 7'b0100000);
        chk("srai_alu_op2", alu_op2, 32'h0000_0403);
        chk("srai_alu_op1", alu_op1, 32'hFFFF_FFE0);
        set_in(vecs[0].op);
        #1;
        chk("add_alu_op2", alu_op2, 32'd20);
        set_in(vecs[8].op);
        #1;
        chk("ill_alu_op1", alu_op1, 32'd0);
        chk("ill_alu_opcode", alu_opcode, 7'd0);
        @(posedge clk); #1;

        // Back-to-back table stream with out_ready=1: no bubbles, no duplicates
        pop_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            e = ref_exp(vecs[i].op);
            e.result  = vecs[i].res;
            e.illegal = vecs[i].ill;
            issue(vecs[i].op, e);
        end
        repeat (3) @(negedge clk);
        chk("stream_pops", pop_cnt, 14);
        chk("stream_no_bubble", last_pop - first_pop, 13);
        chk("stream_sb_empty", sb.size(), 0);
        chk("cnt_after_table", illegal_cnt, exp_cnt);
        chk("cnt_is_4", illegal_cnt, 4'd4);
        @(posedge clk); #1;

        // Latency: accepted in N, visible in N+1
        issue(vecs[0].op, ref_exp(vecs[0].op));
        @(negedge clk);
        chk("lat_out_valid", bus.out_valid, 1'b1);
        chk("lat_out_result", bus.out_result, 32'd30);
        @(negedge clk);
        chk("lat_drained", bus.out_valid, 1'b0);
        @(posedge clk); #1;

        // Backpressure: fill both entries, hold, then drain in order
        bus.out_ready = 1'b0;
        o = mk(32'd50, 32'hDEAD_BEEF, 32'd25, 7'h13, 3'd0, 7'h00, 5'd2);
        issue(o, ref_exp(o));
        o = mk(32'hAAAA_AAAA, 32'h5555_5555, 32'h0FFF, 7'h33, 3'd4, 7'h00, 5'd3);
        issue(o, ref_exp(o));
        @(negedge clk);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_head", bus.out_result, 32'd75);
        repeat (2) @(negedge clk);
        chk("bp_head_stable", bus.out_result, 32'd75);
        chk("bp_head_rd", bus.out_rd, 5'd2);
        chk("bp_tail_exp", sb[1].result, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_drained", sb.size(), 0);
        @(posedge clk); #1;

        // Flush with two buffered entries and an illegal op offered
        bus.out_ready = 1'b0;
        issue(vecs[0].op, ref_exp(vecs[0].op));
        issue(vecs[13].op, ref_exp(vecs[13].op));
        set_in(vecs[8].op);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_full", bus.in_ready, 1'b0);
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", bus.out_valid, 1'b0);
        chk("fl_in_ready", bus.in_ready, 1'b1);
        chk("fl_cnt", illegal_cnt, exp_cnt);
        @(posedge clk); #1;

        // Flush on an empty buffer with an acceptable illegal op: dropped, not counted
        bus.out_ready = 1'b1;
        set_in(vecs[9].op);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fl2_out_valid", bus.out_valid, 1'b0);
        chk("fl2_cnt", illegal_cnt, 4'd4);
        @(posedge clk); #1;

        // Saturation of the illegal counter (4 bits here)
        for (int i = 0; i < 11; i++)
            issue(vecs[8 + (i % 4)].op, ref_exp(vecs[8 + (i % 4)].op));
        @(negedge clk);
        chk("sat_reach", illegal_cnt, 4'hF);
        @(posedge clk); #1;
        issue(vecs[9].op, ref_exp(vecs[9].op));
        @(negedge clk);
        chk("sat_hold", illegal_cnt, 4'hF);
        chk("sat_model", illegal_cnt, exp_cnt);
        @(posedge clk); #1;

        // Reset in the middle of a stream
        bus.out_ready = 1'b0;
        issue(vecs[0].op, ref_exp(vecs[0].op));
        issue(vecs[5].op, ref_exp(vecs[5].op));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", bus.out_valid, 1'b0);
        chk("mrst_out_result", bus.out_result, 32'd0);
        chk("mrst_out_rd", bus.out_rd, 5'd0);
        chk("mrst_cnt", illegal_cnt, 4'd0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst_in_ready", bus.in_ready, 1'b1);
        chk("mrst_empty", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        o = mk(32'd7, 32'd8, 32'h0FFF, 7'h33, 3'd0, 7'h00, 5'd17);
        issue(o, ref_exp(o));
        @(negedge clk);
        chk("mrst_resume", bus.out_result, 32'd15);
        repeat (2) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage sequencer for the shared combinational alu_top.
- Accepts decoded R-type/I-type ALU ops from ID/EX over a valid/ready handshake.
- Selects op2 (rs2 or imm), legalises func7 and detects illegal encodings, then drives alu_top.
- Captures result and flags into a 2-entry output skid buffer toward EX/MEM; supports flush and keeps a saturating illegal-op counter.

Parameters:
- XLEN, 32, datapath width.
- RD_W, 5, destination register index width.
- CNT_W, 16, illegal-op counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; drops buffered entries and the same-cycle input.
- in_valid  in  1  input op valid.
- in_ready  out  1  controller can accept.
- in_op1  in  XLEN  rs1 value.
- in_rs2  in  XLEN  rs2 value.
- in_imm  in  XLEN  sign-extended immediate; [11:5] carry shift func7 for I-type shifts.
- in_opcode  in  7  instruction opcode.
- in_func3  in  3  func3.
- in_func7  in  7  func7 (R-type only).
- in_rd  in  RD_W  destination register.
- alu_op1  out  XLEN  to alu_top op1.
- alu_op2  out  XLEN  to alu_top op2.
- alu_imm  out  XLEN  to alu_top imm.
- alu_opcode  out  7  to alu_top opcode.
- alu_func3  out  3  to alu_top func3.
- alu_func7  out  7  to alu_top func7.
- alu_result  in  XLEN  from alu_top result_alu.
- alu_flags  in  4  {carry, zero, negative, overflow} from alu_top.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_result  out  XLEN  head result.
- out_flags  out  4  head flags.
- out_rd  out  RD_W  head destination.
- out_illegal  out  1  head op was illegal.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal ops.

Behaviour:
- ALU drive is combinational from in_*:
  - alu_op1 = in_op1.
  - alu_op2 = in_rs2 when opcode 0110011, else in_imm.
  - alu_imm = in_imm.
  - alu_opcode and alu_func3 pass through.
- func7 legalisation:
  - R-type: in_func7.
  - I-type with func3=101: in_imm[11:5].
  - Other I-type: 0000000 (ADDI never subtracts).
- Illegal when any of:
  - opcode is not 0110011 or 0010011;
  - R-type func7 is not 0000000 or 0100000;
  - R-type func7=0100000 with func3 not 000 or 101;
  - I-type func3=001 with imm[11:5]!=0;
  - I-type func3=101 with imm[11:5] not 0000000 or 0100000.
- Illegal ops drive all alu_* outputs to 0 and store result=0, flags=0, illegal=1.
- Accept = in_valid & in_ready & ~flush.
- Pop = out_valid & out_ready.
- Buffer: count register 0..2, head/tail 1-bit pointers; entry = {result, flags, rd, illegal}.
  - out_valid = (count != 0); in_ready = (count != 2).
  - Head entry is driven on out_*; out_* are 0 when count=0.
- Latency: an op accepted in cycle N appears on out_* in cycle N+1.
- Count transitions:
  - push only: +1; pop only: -1; push+pop at count 1: stays 1, new entry becomes the head next cycle.
  - count=2: in_ready=0, so push+pop cannot occur.
- Backpressure: head entry is held stable while out_valid & ~out_ready.
- flush (synchronous, priority over push and pop): count=0, pointers=0, same-cycle input dropped, illegal_cnt unaffected by the dropped op.
- illegal_cnt increments on accept of an illegal op and saturates at all-ones.
- Reset (async assert, sync-released use): count=0, pointers=0, all out_*=0, illegal_cnt=0, in_ready=1 after the first edge.
- Mid-operation reset discards buffered entries.

Decomposition:
- alu_ctrl_pkg holds:
  - opcode constants OPC_RTYPE=0110011 and OPC_ITYPE=0010011;
  - F7_BASE=0000000 and F7_ALT=0100000;
  - func3 constants for ADD, SLL, SLT, SLTU, XOR, SR, OR, AND;
  - the buffer-entry struct/width.
- One combinational sub-module, alu_op_decode, owns op2 select, func7 legalisation and the illegal flag.
- The skid buffer, counter and handshake live in alu_issue_ctrl.
- alu_top is instantiated by the parent stage, not inside this block.

Test Plan:
- ADD: op1=10, rs2=20, opcode 0110011, func3 000, func7 0 -> next cycle out_valid=1, out_result=30, out_illegal=0.
- SRAI: opcode 0010011, func3 101, op1=0xFFFFFFE0, imm=0x00000403 -> alu_func7=0100000, alu_op2=0x403, out_result=0xFFFFFFFC.
- Backpressure: hold out_ready=0 and issue ADDI 50+25 then XOR 0xAAAAAAAA^0x55555555 -> count=2, in_ready=0. Raise out_ready -> 75 then 0xFFFFFFFF, in order, with no loss.
- Simultaneous push/pop at count 1 -> out_valid stays 1; over a stream of 8 ops there are no bubbles and no duplicates.
- Illegal: opcode 0110011 with func7=0000001, and I-type func3 001 with imm=0x405 -> out_illegal=1, out_result=0, illegal_cnt=2. Force the counter to all-ones and it stays there on the next illegal op.
- Flush with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped op not counted. Assert rst_n=0 mid-stream -> all outputs 0 immediately.
